egress_header_rewrite: RTL and testbench

- Egress-side counterpart of the ingress drop/check stage in the router output_port_lookup pipeline; sits after the lookup and before the output queues.
- On each forwarded IPv4 packet it fills in the Ethernet addresses for the chosen output port: source MAC from the port MAC registers, destination MAC from the next hop carried in TUSER.
- It also decrements TTL and patches the IP header checksum incrementally, so the downstream checker sees a valid header.
- Non-IPv4 packets, packets with TTL <= 1, and packets not bound to exactly one MAC port pass through untouched.

---
 rtl/egress_header_rewrite.sv | 195 +++++++++++++++++++
 tb/tb_egress_header_rewrite.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_header_rewrite.sv
// Egress header rewrite: fills Ethernet addresses for the chosen MAC port on IPv4 header beats.
// Define HDR_REWRITE_TTL_EN to also decrement TTL and patch the checksum incrementally.
module egress_header_rewrite #(
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned DST_PORT_POS         = 24,
    parameter int unsigned NH_MAC_POS           = 32
) (
    input  logic                                AXI_ACLK,
    input  logic                                reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    output logic                                S_AXIS_TREADY,
    input  logic                                S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    input  logic                                M_AXIS_TREADY,
    output logic                                M_AXIS_TLAST,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       clear_counters,
    output logic [31:0]                         rewritten_count,
    output logic [31:0]                         bypass_count
);

    localparam int unsigned DW        = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SW        = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW        = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned DMAC_LSB  = 208;
    localparam int unsigned SMAC_LSB  = 160;
    localparam int unsigned ETYPE_LSB = 144;
`ifdef HDR_REWRITE_TTL_EN
    localparam int unsigned TTL_LSB   = 72;
    localparam int unsigned CSUM_LSB  = 48;
`endif

    typedef enum logic {
        ST_HEADER = 1'b0,
        ST_BODY   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            m_valid_q;
    logic [DW-1:0]   m_data_q;
    logic [SW-1:0]   m_strb_q;
    logic [UW-1:0]   m_user_q;
    logic            m_last_q;
    logic [31:0]     rw_cnt_q, rw_cnt_d;
    logic [31:0]     by_cnt_q, by_cnt_d;

    logic            s_tready_c;
    logic            accept_c;
    logic            is_hdr_c;
    logic [3:0]      port_sel_c;
    logic            one_hot_c;
    logic [1:0]      port_idx_c;
    logic            ttl_ok_c;
    logic            rewrite_c;
    logic [47:0]     src_mac_c;
    logic [DW-1:0]   out_data_c;
`ifdef HDR_REWRITE_TTL_EN
    logic [7:0]      ttl_c;
    logic [16:0]     csum_sum_c;
`endif

    logic            unused_mac_hi;
    assign unused_mac_hi = ^{mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                             mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

    // Single output register stage: accept whenever the output slot is free or draining.
    assign s_tready_c    = !m_valid_q || M_AXIS_TREADY;
    assign accept_c      = S_AXIS_TVALID && s_tready_c;
    assign is_hdr_c      = (state_q == ST_HEADER);
    assign S_AXIS_TREADY = s_tready_c;

    // Packet framing FSM.
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            if (S_AXIS_TLAST) begin
                state_d = ST_HEADER;
            end else begin
                state_d = ST_BODY;
            end
        end
    end

    // Header qualification and port selection.
    always_comb begin
        port_sel_c = {S_AXIS_TUSER[DST_PORT_POS+6], S_AXIS_TUSER[DST_PORT_POS+4],
                      S_AXIS_TUSER[DST_PORT_POS+2], S_AXIS_TUSER[DST_PORT_POS]};
        one_hot_c  = 1'b0;
        port_idx_c = 2'd0;
        case (port_sel_c)
            4'b0001: begin one_hot_c = 1'b1; port_idx_c = 2'd0; end
            4'b0010: begin one_hot_c = 1'b1; port_idx_c = 2'd1; end
            4'b0100: begin one_hot_c = 1'b1; port_idx_c = 2'd2; end
            4'b1000: begin one_hot_c = 1'b1; port_idx_c = 2'd3; end
            default: ;
        endcase
        case (port_idx_c)
            2'd0:    src_mac_c = {mac0_high[15:0], mac0_low[31:0]};
            2'd1:    src_mac_c = {mac1_high[15:0], mac1_low[31:0]};
            2'd2:    src_mac_c = {mac2_high[15:0], mac2_low[31:0]};
            default: src_mac_c = {mac3_high[15:0], mac3_low[31:0]};
        endcase
`ifdef HDR_REWRITE_TTL_EN
        ttl_c    = S_AXIS_TDATA[TTL_LSB +: 8];
        ttl_ok_c = (ttl_c > 8'd1);
`else
        ttl_ok_c = 1'b1;
`endif
        rewrite_c = is_hdr_c && (S_AXIS_TDATA[ETYPE_LSB +: 16] == 16'h0800) && one_hot_c && ttl_ok_c;
    end

    // Rewritten header beat; body and bypassed beats pass bit-identical.
    always_comb begin
        out_data_c = S_AXIS_TDATA;
`ifdef HDR_REWRITE_TTL_EN
        csum_sum_c = {1'b0, S_AXIS_TDATA[CSUM_LSB +: 16]} + 17'h00100;
`endif
        if (rewrite_c) begin
            out_data_c[DMAC_LSB +: 48] = S_AXIS_TUSER[NH_MAC_POS +: 48];
            out_data_c[SMAC_LSB +: 48] = src_mac_c;
`ifdef HDR_REWRITE_TTL_EN
            out_data_c[TTL_LSB +: 8]   = ttl_c - 8'd1;
            out_data_c[CSUM_LSB +: 16] = csum_sum_c[15:0] + 16'(csum_sum_c[16]);
`endif
        end
    end

    // Per-packet counters; clear wins over a same-cycle increment.
    always_comb begin
        rw_cnt_d = rw_cnt_q;
        by_cnt_d = by_cnt_q;
        if (clear_counters == C_S_AXI_DATA_WIDTH'(1)) begin
            rw_cnt_d = 32'd0;
            by_cnt_d = 32'd0;
        end else if (accept_c && is_hdr_c) begin
            if (rewrite_c) begin
                rw_cnt_d = rw_cnt_q + 32'd1;
            end else begin
                by_cnt_d = by_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q   <= ST_HEADER;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_strb_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            rw_cnt_q  <= 32'd0;
            by_cnt_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            rw_cnt_q <= rw_cnt_d;
            by_cnt_q <= by_cnt_d;
            if (s_tready_c) begin
                m_valid_q <= S_AXIS_TVALID;
                if (S_AXIS_TVALID) begin
                    m_data_q <= out_data_c;
                    m_strb_q <= S_AXIS_TSTRB;
                    m_user_q <= S_AXIS_TUSER;
                    m_last_q <= S_AXIS_TLAST;
                end
            end
        end
    end

    assign M_AXIS_TVALID   = m_valid_q;
    assign M_AXIS_TDATA    = m_data_q;
    assign M_AXIS_TSTRB    = m_strb_q;
    assign M_AXIS_TUSER    = m_user_q;
    assign M_AXIS_TLAST    = m_last_q;
    assign rewritten_count = rw_cnt_q;
    assign bypass_count    = by_cnt_q;

endmodule

// File: tb/tb_egress_header_rewrite.sv
// Scoreboard bench for egress_header_rewrite; expected beats are queued at input acceptance.
module tb_egress_header_rewrite;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
        logic         h;
        logic         rw;
    } beat_t;

    logic         AXI_ACLK = 1'b0;
    logic         reset;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TREADY;
    logic         S_AXIS_TLAST;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;
    logic         M_AXIS_TLAST;
    logic [31:0]  mac_low [4];
    logic [31:0]  mac_high[4];
    logic [31:0]  clear_counters;
    logic [31:0]  rewritten_count;
    logic [31:0]  bypass_count;

    int           n_checks = 0;
    int           n_errors = 0;
    beat_t        sb[$];
    logic [31:0]  model_rw = '0;
    logic [31:0]  model_by = '0;
    logic         in_hdr = 1'b1;
    logic         prev_rst = 1'b0;
    logic [255:0] last_hdr = '0;
    int           rdy_mode = 0;
    logic         rdy_pat[$];

    always #5 AXI_ACLK = ~AXI_ACLK;

    egress_header_rewrite dut (
        .AXI_ACLK        (AXI_ACLK),
        .reset           (reset),
        .S_AXIS_TDATA    (S_AXIS_TDATA),
        .S_AXIS_TSTRB    (S_AXIS_TSTRB),
        .S_AXIS_TUSER    (S_AXIS_TUSER),
        .S_AXIS_TVALID   (S_AXIS_TVALID),
        .S_AXIS_TREADY   (S_AXIS_TREADY),
        .S_AXIS_TLAST    (S_AXIS_TLAST),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TSTRB    (M_AXIS_TSTRB),
        .M_AXIS_TUSER    (M_AXIS_TUSER),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TREADY   (M_AXIS_TREADY),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .mac0_low        (mac_low[0]),
        .mac0_high       (mac_high[0]),
        .mac1_low        (mac_low[1]),
        .mac1_high       (mac_high[1]),
        .mac2_low        (mac_low[2]),
        .mac2_high       (mac_high[2]),
        .mac3_low        (mac_low[3]),
        .mac3_high       (mac_high[3]),
        .clear_counters  (clear_counters),
        .rewritten_count (rewritten_count),
        .bypass_count    (bypass_count)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted beat.
    function automatic beat_t model(input logic [255:0] d, input logic [31:0] s,
                                    input logic [127:0] u, input logic l, input logic h);
        beat_t      b;
        logic [3:0] p;
        logic [7:0] ttl;
        int         sel;
        int         c;
        b.d = d; b.s = s; b.u = u; b.l = l; b.h = h; b.rw = 1'b0;
        if (!h) return b;
        p   = {u[30], u[28], u[26], u[24]};
        ttl = d[79:72];
        if (d[159:144] != 16'h0800 || $countones(p) != 1) return b;
`ifdef HDR_REWRITE_TTL_EN
        if (ttl <= 8'd1) return b;
`endif
        sel = p[0] ? 0 : (p[1] ? 1 : (p[2] ? 2 : 3));
        b.d[255:208] = u[79:32];
        b.d[207:160] = {mac_high[sel][15:0], mac_low[sel]};
`ifdef HDR_REWRITE_TTL_EN
        b.d[79:72] = ttl - 8'd1;
        c = int'(d[63:48]) + 256;
        if (c > 65535) c = c - 65535;
        b.d[63:48] = 16'(c);
`endif
        b.rw = 1'b1;
        return b;
    endfunction

    // Monitor at the falling edge: inputs and outputs are settled for the next rising edge.
    always @(negedge AXI_ACLK) begin
        beat_t e;
        logic  acc;
        logic  hdr;
        if (reset) begin
            sb.delete();
            model_rw = '0;
            model_by = '0;
            in_hdr   = 1'b1;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                check_eq("post_reset_tvalid", 256'(M_AXIS_TVALID), 256'(0));
                check_eq("post_reset_tdata", M_AXIS_TDATA, 256'(0));
            end
            prev_rst = 1'b0;
            check_eq("rewritten_count", 256'(rewritten_count), 256'(model_rw));
            check_eq("bypass_count", 256'(bypass_count), 256'(model_by));
            if (M_AXIS_TVALID) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_beat_tvalid", 256'(M_AXIS_TVALID), 256'(0));
                end else begin
                    e = sb[0];
                    check_eq("tdata", M_AXIS_TDATA, e.d);
                    check_eq("tstrb", 256'(M_AXIS_TSTRB), 256'(e.s));
                    check_eq("tuser", 256'(M_AXIS_TUSER), 256'(e.u));
                    check_eq("tlast", 256'(M_AXIS_TLAST), 256'(e.l));
                    if (M_AXIS_TREADY) begin
                        if (e.h) last_hdr = M_AXIS_TDATA;
                        void'(sb.pop_front());
                    end
                end
            end
            acc = S_AXIS_TVALID && S_AXIS_TREADY;
            hdr = in_hdr;
            if (acc) begin
                e = model(S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST, hdr);
                sb.push_back(e);
                in_hdr = S_AXIS_TLAST;
            end
            if (clear_counters == 32'd1) begin
                model_rw = '0;
                model_by = '0;
            end else if (acc && hdr) begin
                if (e.rw) model_rw = model_rw + 32'd1;
                else      model_by = model_by + 32'd1;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = scripted pattern then ready.
    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge AXI_ACLK);
            #2;
            case (rdy_mode)
                1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                2:       M_AXIS_TREADY = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
                default: M_AXIS_TREADY = 1'b1;
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [15:0] et, input logic [7:0] ttl,
                                            input logic [15:0] cs);
        logic [255:0] d;
        d = rnd256();
        d[159:144] = et;
        d[79:72]   = ttl;
        d[63:48]   = cs;
        return d;
    endfunction

    function automatic logic [127:0] mk_user(input logic [3:0] p, input logic [47:0] nh);
        logic [127:0] u;
        u = {$urandom(), $urandom(), $urandom(), $urandom()};
        u[24] = p[0]; u[26] = p[1]; u[28] = p[2]; u[30] = p[3];
        u[79:32] = nh;
        return u;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
        int   waited = 0;
        logic acc    = 1'b0;
        S_AXIS_TDATA  = d;
        S_AXIS_TUSER  = u;
        S_AXIS_TLAST  = l;
        S_AXIS_TSTRB  = $urandom();
        S_AXIS_TVALID = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge AXI_ACLK);
            acc = S_AXIS_TREADY;
            waited++;
        end
        if (!acc) check_eq("accept_timeout", 256'(S_AXIS_TREADY), 256'(1));
        @(posedge AXI_ACLK);
        #1;
    endtask

    task automatic send_pkt(input int n, input logic [255:0] hdr, input logic [127:0] u);
        for (int i = 0; i < n; i++) begin
            send_beat((i == 0) ? hdr : rnd256(), u, (i == n - 1));
        end
    endtask

    task automatic idle(input int n);
        S_AXIS_TVALID = 1'b0;
        repeat (n) @(posedge AXI_ACLK);
        #1;
    endtask

    initial begin
        int waited;
        reset          = 1'b1;
        S_AXIS_TVALID  = 1'b0;
        S_AXIS_TDATA   = '0;
        S_AXIS_TSTRB   = '0;
        S_AXIS_TUSER   = '0;
        S_AXIS_TLAST   = 1'b0;
        clear_counters = '0;
        mac_low[0] = 32'h1111_2222; mac_high[0] = 32'h0000_0A00;
        mac_low[1] = 32'h0C0D_0E0F; mac_high[1] = 32'hDEAD_0A0B;
        mac_low[2] = 32'h3333_4444; mac_high[2] = 32'h0000_0B00;
        mac_low[3] = 32'h5555_6666; mac_high[3] = 32'hFFFF_0C00;
        repeat (3) @(posedge AXI_ACLK);
        #1;
        reset = 1'b0;
        check_eq("reset_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        check_eq("reset_tdata", M_AXIS_TDATA, 256'(0));
        check_eq("reset_tuser_tstrb_tlast", 256'({M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST}), 256'(0));
        check_eq("reset_counts", 256'({rewritten_count, bypass_count}), 256'(0));

        // Basic rewrite.
        send_pkt(2, mk_hdr(16'h0800, 8'h40, 16'hB861), mk_user(4'b0010, 48'h0011_2233_4455));
        idle(3);
        check_eq("p1_dst_mac", 256'(last_hdr[255:208]), 256'(48'h0011_2233_4455));
        check_eq("p1_src_mac", 256'(last_hdr[207:160]), 256'(48'h0A0B_0C0D_0E0F));
`ifdef HDR_REWRITE_TTL_EN
        check_eq("p1_ttl", 256'(last_hdr[79:72]), 256'(8'h3F));
        check_eq("p1_csum", 256'(last_hdr[63:48]), 256'(16'hB961));
`else
        check_eq("p1_ttl", 256'(last_hdr[79:72]), 256'(8'h40));
        check_eq("p1_csum", 256'(last_hdr[63:48]), 256'(16'hB861));
`endif
        check_eq("p1_rewritten", 256'(rewritten_count), 256'(1));

        // Checksum end-around carry.
        send_pkt(2, mk_hdr(16'h0800, 8'h10, 16'hFF50), mk_user(4'b0001, 48'hAABB_CCDD_EEFF));
        idle(3);
`ifdef HDR_REWRITE_TTL_EN
        check_eq("p2_csum", 256'(last_hdr[63:48]), 256'(16'h0051));
        check_eq("p2_ttl", 256'(last_hdr[79:72]), 256'(8'h0F));
`else
        check_eq("p2_csum", 256'(last_hdr[63:48]), 256'(16'hFF50));
        check_eq("p2_ttl", 256'(last_hdr[79:72]), 256'(8'h10));
`endif

        // Bypass candidates: ARP, TTL=1, two ports selected.
        send_pkt(2, mk_hdr(16'h0806, 8'h40, 16'h1234), mk_user(4'b0010, 48'h0011_2233_4455));
        send_pkt(2, mk_hdr(16'h0800, 8'h01, 16'h1234), mk_user(4'b0010, 48'h0011_2233_4455));
        send_pkt(2, mk_hdr(16'h0800, 8'h40, 16'h1234), mk_user(4'b0011, 48'h0011_2233_4455));
        idle(3);
`ifdef HDR_REWRITE_TTL_EN
        check_eq("bypass_total", 256'(bypass_count), 256'(3));
`else
        check_eq("bypass_total", 256'(bypass_count), 256'(2));
`endif

        // Backpressure during a 4-beat packet.
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rdy_mode = 2;
        send_pkt(4, mk_hdr(16'h0800, 8'h20, 16'h0F0F), mk_user(4'b0100, 48'h0102_0304_0506));
        idle(6);
        rdy_mode = 0;

        // Single-beat packet back-to-back with a 3-beat packet.
        send_beat(mk_hdr(16'h0800, 8'h33, 16'h4444), mk_user(4'b1000, 48'h1020_3040_5060), 1'b1);
        send_pkt(3, mk_hdr(16'h0800, 8'h34, 16'h5555), mk_user(4'b0001, 48'h7080_90A0_B0C0));
        idle(3);

        // Clear coincident with a header accept.
        clear_counters = 32'd1;
        send_beat(mk_hdr(16'h0800, 8'h40, 16'h0000), mk_user(4'b0010, 48'h0000_0000_0001), 1'b1);
        clear_counters = 32'd0;
        check_eq("clear_rewritten", 256'(rewritten_count), 256'(0));
        check_eq("clear_bypass", 256'(bypass_count), 256'(0));
        idle(3);

        // Reset mid-packet, then a fresh packet must be treated as a header.
        send_beat(mk_hdr(16'h0800, 8'h40, 16'h2222), mk_user(4'b0010, 48'h0A0A_0A0A_0A0A), 1'b0);
        S_AXIS_TVALID = 1'b0;
        reset = 1'b1;
        @(posedge AXI_ACLK);
        #1;
        reset = 1'b0;
        check_eq("midpkt_reset_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        send_pkt(2, mk_hdr(16'h0800, 8'h40, 16'h3333), mk_user(4'b0100, 48'h0B0B_0B0B_0B0B));
        idle(3);
        check_eq("after_reset_rewritten", 256'(rewritten_count), 256'(1));

        // Random traffic under random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 12; k++) begin
            logic [15:0] et;
            logic [7:0]  ttl;
            et  = ($urandom_range(0, 3) == 0) ? 16'h86DD : 16'h0800;
            ttl = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'h40;
            send_pkt(int'($urandom_range(1, 4)), mk_hdr(et, ttl, 16'($urandom())),
                     mk_user(4'($urandom()), {$urandom(), 16'($urandom())}));
        end
        S_AXIS_TVALID = 1'b0;
        rdy_mode = 0;

        waited = 0;
        while (sb.size() > 0 && waited < 50) begin
            @(posedge AXI_ACLK);
            waited++;
        end
        #1;
        check_eq("drain_empty", 256'(sb.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
